// File: rtl/sn_pkg.sv
// -----------------------------------------------------------------------------
// sn_pkg
//   Shared constants and types for the stochastic-core operand serializer.
//   - SN_DATA_W      operand width (data bits per frame)
//   - SN_FRAME_LEN   bits per serial frame (data bits + one dummy bit)
//   - SN_EPOCH_MAX   last epoch counter value; one epoch is SN_EPOCH_MAX+1
//                    cycles, matching the core's clk_counter period
//   - sn_operand_t   one operand as carried on a serial line
//   - sn_tx_state_e  transmitter state (IDLE until the first pair is active)
//   - sn_frame_inc   frame position step with wrap at the last frame bit
// -----------------------------------------------------------------------------
package sn_pkg;

  localparam int unsigned SN_DATA_W    = 9;
  localparam int unsigned SN_FRAME_LEN = 10;
  localparam int unsigned SN_EPOCH_W   = 18;
  localparam int unsigned SN_FRAME_W   = 4;

  localparam logic [SN_EPOCH_W-1:0] SN_EPOCH_MAX = 18'd131072;

  typedef logic [SN_DATA_W-1:0]  sn_operand_t;
  typedef logic [SN_EPOCH_W-1:0] sn_epoch_cnt_t;
  typedef logic [SN_FRAME_W-1:0] sn_frame_cnt_t;

  typedef enum logic {
    SN_TX_IDLE = 1'b0,
    SN_TX_RUN  = 1'b1
  } sn_tx_state_e;

  // Next frame position: counts 0..last and wraps back to 0.
  function automatic sn_frame_cnt_t sn_frame_inc(input sn_frame_cnt_t k,
                                                 input sn_frame_cnt_t last);
    sn_frame_cnt_t nxt;
    if (k == last) begin
      nxt = '0;
    end else begin
      nxt = k + sn_frame_cnt_t'(1);
    end
    return nxt;
  endfunction

endpackage : sn_pkg

// File: rtl/sn_frame_shifter.sv
// -----------------------------------------------------------------------------
// sn_frame_shifter
//   Holds the active operand for one serial line and selects the bit that
//   belongs at a given frame position. Positions 0..DATA_W-1 carry the
//   operand LSB first; any position at or beyond DATA_W is the dummy bit (0).
//   The selected bit is combinational; the parent registers it.
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous reset, active-HIGH despite the name
//   load_i       in   replace the held operand with data_i on this edge
//   data_i       in   operand to hold (DATA_W bits)
//   frame_cnt_i  in   current frame position
//   bit_o        out  line bit for frame_cnt_i
// -----------------------------------------------------------------------------
module sn_frame_shifter
  import sn_pkg::*;
#(
  parameter int unsigned DATA_W = SN_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [SN_FRAME_W-1:0] frame_cnt_i,
  output logic                  bit_o
);

  localparam sn_frame_cnt_t DUMMY_POS = SN_FRAME_W'(DATA_W);

  logic [DATA_W-1:0] op_q;
  logic [DATA_W-1:0] op_d;

  always_comb begin
    op_d = op_q;
    if (load_i) begin
      op_d = data_i;
    end
  end

  // The codebase reset is named rst_n but is asserted high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      op_q <= '0;
    end else begin
      op_q <= op_d;
    end
  end

  always_comb begin
    bit_o = 1'b0;
    if (frame_cnt_i < DUMMY_POS) begin
      bit_o = op_q[frame_cnt_i];
    end
  end

endmodule : sn_frame_shifter

// File: rtl/sn_operand_serializer.sv
// -----------------------------------------------------------------------------
// sn_operand_serializer
//   Host-side transmitter for the stochastic core's serial operand input.
//   Operand pairs (A, B) arrive over a valid/ready handshake into a 1-deep
//   pending buffer. At each epoch boundary the pending pair (or a pair being
//   accepted in that very cycle) becomes the active pair, so the core never
//   sees a frame that mixes two pairs. The active pair is streamed forever as
//   back-to-back frames: DATA_W data bits LSB first, then one dummy 0 bit.
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous reset, active-HIGH despite the name
//   in_valid     in   operand pair offered
//   in_ready     out  pending buffer empty
//   in_a         in   operand A (drives serial line A)
//   in_b         in   operand B (drives serial line B)
//   ser_a        out  serial stream A, registered
//   ser_b        out  serial stream B, registered
//   frame_start  out  high while ser_a/ser_b carry data bit 0
//   epoch_wrap   out  high in the last cycle of each epoch
//   loaded       out  an operand pair is active (state RUN)
//
// Handshake: a pair transfers on any rising edge where in_valid && in_ready.
// in_ready depends only on registered state (never on in_valid). While
// in_ready is low, in_valid/in_a/in_b are ignored and may change freely; an
// offer simply waits until in_ready returns high.
// -----------------------------------------------------------------------------
module sn_operand_serializer
  import sn_pkg::*;
#(
  parameter int unsigned              DATA_W    = SN_DATA_W,
  parameter int unsigned              FRAME_LEN = SN_FRAME_LEN,
  parameter logic [SN_EPOCH_W-1:0]    EPOCH_MAX = SN_EPOCH_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              ser_a,
  output logic              ser_b,
  output logic              frame_start,
  output logic              epoch_wrap,
  output logic              loaded
);

  // Frame layout only works with exactly one dummy bit after the data, and
  // the frame position must fit the 4-bit counter.
  if (DATA_W != FRAME_LEN - 1) begin : g_bad_frame_len
    $error("sn_operand_serializer: DATA_W must equal FRAME_LEN-1");
  end
  if (FRAME_LEN > (1 << SN_FRAME_W)) begin : g_bad_frame_w
    $error("sn_operand_serializer: FRAME_LEN does not fit the frame counter");
  end

  localparam sn_frame_cnt_t FRAME_LAST = SN_FRAME_W'(FRAME_LEN - 1);

  // Counters
  sn_epoch_cnt_t epoch_cnt_q, epoch_cnt_d;
  sn_frame_cnt_t frame_cnt_q, frame_cnt_d;

  // Pending buffer
  logic [DATA_W-1:0] pend_a_q, pend_a_d;
  logic [DATA_W-1:0] pend_b_q, pend_b_d;
  logic              pend_full_q, pend_full_d;

  // State and registered line outputs
  sn_tx_state_e state_q, state_d;
  logic         ser_a_q, ser_b_q, frame_start_q;

  // Active-pair load path into the shifters
  logic              wrap;
  logic              accept;
  logic              load_active;
  logic [DATA_W-1:0] load_a, load_b;
  logic              bit_a, bit_b;

  assign wrap     = (epoch_cnt_q == EPOCH_MAX);
  assign in_ready = !pend_full_q;
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Counters. The frame counter is forced back to 0 after the epoch's last
  // cycle so each epoch starts on a frame boundary; the trailing partial
  // frame of the previous epoch is simply cut short.
  // ---------------------------------------------------------------------------
  always_comb begin
    epoch_cnt_d = epoch_cnt_q + sn_epoch_cnt_t'(1);
    frame_cnt_d = sn_frame_inc(frame_cnt_q, FRAME_LAST);
    if (wrap) begin
      epoch_cnt_d = '0;
      frame_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer / swap control.
  //   boundary & pending full  -> pending becomes active, buffer empties
  //   boundary & accept        -> incoming pair goes straight to active
  //   accept (no boundary)     -> incoming pair parks in pending
  // An accept can never coincide with a full buffer (in_ready is low), so
  // the first two cases are exclusive in practice and nothing is overwritten.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_a_d    = pend_a_q;
    pend_b_d    = pend_b_q;
    pend_full_d = pend_full_q;
    state_d     = state_q;
    load_active = 1'b0;
    load_a      = pend_a_q;
    load_b      = pend_b_q;

    if (wrap && pend_full_q) begin
      load_active = 1'b1;
      pend_full_d = 1'b0;
      state_d     = SN_TX_RUN;
    end else if (wrap && accept) begin
      load_active = 1'b1;
      load_a      = in_a;
      load_b      = in_b;
      state_d     = SN_TX_RUN;
    end else if (accept) begin
      pend_a_d    = in_a;
      pend_b_d    = in_b;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      epoch_cnt_q <= '0;
      frame_cnt_q <= '0;
      pend_a_q    <= '0;
      pend_b_q    <= '0;
      pend_full_q <= 1'b0;
    end else begin
      epoch_cnt_q <= epoch_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      pend_a_q    <= pend_a_d;
      pend_b_q    <= pend_b_d;
      pend_full_q <= pend_full_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Active operand holders, one per serial line.
  // ---------------------------------------------------------------------------
  sn_frame_shifter #(
    .DATA_W (DATA_W)
  ) u_shift_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_active),
    .data_i      (load_a),
    .frame_cnt_i (frame_cnt_q),
    .bit_o       (bit_a)
  );

  sn_frame_shifter #(
    .DATA_W (DATA_W)
  ) u_shift_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_active),
    .data_i      (load_b),
    .frame_cnt_i (frame_cnt_q),
    .bit_o       (bit_b)
  );

  // ---------------------------------------------------------------------------
  // State and line outputs. Outputs lag the frame counter by one cycle, so
  // a swap at the boundary edge still emits the old pair's last bit and the
  // new pair's bit 0 appears one cycle after the counter shows position 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= SN_TX_IDLE;
      ser_a_q       <= 1'b0;
      ser_b_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == SN_TX_RUN) begin
        ser_a_q       <= bit_a;
        ser_b_q       <= bit_b;
        frame_start_q <= (frame_cnt_q == '0);
      end else begin
        ser_a_q       <= 1'b0;
        ser_b_q       <= 1'b0;
        frame_start_q <= 1'b0;
      end
    end
  end

  assign ser_a       = ser_a_q;
  assign ser_b       = ser_b_q;
  assign frame_start = frame_start_q;
  assign epoch_wrap  = wrap;
  assign loaded      = (state_q == SN_TX_RUN);

endmodule : sn_operand_serializer
